// File: rtl/mux_pkg.sv
// Shared definitions for the two-source mux select arbiter.
//
// Contents:
//   state_t            FSM encoding: IDLE=0, OWN_A=1, OWN_B=2
//   src_t              identifies a source; used for the last-served flag
//   BURST_LEN_DEFAULT  default maximum number of consecutive grant cycles
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        SRC_B = 1'b0,
        SRC_A = 1'b1
    } src_t;

    localparam int BURST_LEN_DEFAULT = 4;

endpackage

// File: rtl/mux_sel_arbiter.sv
// Two-source arbiter that owns the select line of a downstream 1-bit mux.
// A source keeps the path for at most BURST_LEN consecutive cycles; ties in
// IDLE go to the source that was not served last. All outputs are registers,
// so a request sampled on one edge shows up as a grant after that edge.
//
// Parameters:
//   BURST_LEN  maximum consecutive grant cycles per source (1..255)
//   CNT_W      burst counter width, 2**CNT_W > BURST_LEN
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   req_a      source a requests the path
//   req_b      source b requests the path
//   done       current owner releases early (ignored in IDLE)
//   gnt_a      source a owns the path
//   gnt_b      source b owns the path
//   x          mux select: 1 routes a, 0 routes b; holds its value in IDLE
//   busy       gnt_a | gnt_b
//   burst_cnt  completed cycles in the current grant
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEFAULT,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             done,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             x,
    output logic             busy,
    output logic [CNT_W-1:0] burst_cnt
);

    // Counter value on the last allowed cycle of a burst.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_reg,  state_next;
    src_t             last_reg,   last_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             gnt_a_reg,  gnt_a_next;
    logic             gnt_b_reg,  gnt_b_next;
    logic             busy_reg,   busy_next;
    logic             x_reg,      x_next;

    logic             burst_end;
    logic             release_a;
    logic             release_b;
    logic             entering;

    assign burst_end = (cnt_reg == CNT_LAST);
    assign release_a = !req_a || done || burst_end;
    assign release_b = !req_b || done || burst_end;

    // State and all output registers. Reset is asynchronous so a mid-grant
    // reset drops the grants immediately instead of finishing the burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= SRC_B;     // a wins the first tie
            cnt_reg   <= '0;
            gnt_a_reg <= 1'b0;
            gnt_b_reg <= 1'b0;
            busy_reg  <= 1'b0;
            x_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            gnt_a_reg <= gnt_a_next;
            gnt_b_reg <= gnt_b_next;
            busy_reg  <= busy_next;
            x_reg     <= x_next;
        end
    end

    // Next-state logic. A release hands over directly to the other source if
    // it is waiting; otherwise the FSM rests in IDLE for a cycle, which is what
    // produces the single idle cycle before an expired owner is regranted.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_a && req_b)
                    state_next = (last_reg == SRC_A) ? OWN_B : OWN_A;
                else if (req_a)
                    state_next = OWN_A;
                else if (req_b)
                    state_next = OWN_B;
            end
            OWN_A: begin
                if (release_a)
                    state_next = req_b ? OWN_B : IDLE;
            end
            OWN_B: begin
                if (release_b)
                    state_next = req_a ? OWN_A : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being
    // entered so every output changes on the same edge as the grant.
    always_comb begin
        // A grant starts whenever the next state is an OWN state different
        // from the current one; staying in the same OWN state is a continuation.
        entering   = (state_next != IDLE) && (state_next != state_reg);

        gnt_a_next = (state_next == OWN_A);
        gnt_b_next = (state_next == OWN_B);
        busy_next  = (state_next != IDLE);

        // Select only moves when a grant asserts; IDLE keeps the old route.
        x_next = x_reg;
        if (state_next == OWN_A)
            x_next = 1'b1;
        else if (state_next == OWN_B)
            x_next = 1'b0;

        last_next = last_reg;
        if (entering)
            last_next = (state_next == OWN_A) ? SRC_A : SRC_B;

        // Release happens at CNT_LAST, so the increment never wraps.
        if (entering || (state_next == IDLE))
            cnt_next = '0;
        else
            cnt_next = cnt_reg + 1'b1;
    end

    assign gnt_a     = gnt_a_reg;
    assign gnt_b     = gnt_b_reg;
    assign busy      = busy_reg;
    assign x         = x_reg;
    assign burst_cnt = cnt_reg;

endmodule
